aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_round_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } aes_state_e;

    localparam int unsigned NrAes128 = 10;
    localparam int unsigned NrAes192 = 12;
    localparam int unsigned NrAes256 = 14;

    localparam int unsigned RoundW = 4;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: initial AddRoundKey, NR-1 full rounds and a final
// round without MixColumns. Define AES_ABORT_EN to add the abort_i input.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NrAes128,
    parameter int unsigned RW = RoundW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          key_ready_i,
    output logic [RW-1:0] round_o,
    output logic          dp_valid_o,
    output logic          dp_load_o,
    output logic          dp_mix_en_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
`ifdef AES_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o
);

    localparam logic [RW-1:0] LastMixRound = RW'(NR - 1);

    aes_state_e    state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          in_ready_q, out_valid_q, busy_q;
    logic          dp_valid, dp_load, dp_mix_en;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        dp_valid  = 1'b0;
        dp_load   = 1'b0;
        dp_mix_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                // in_ready_q gates acceptance so nothing is taken before the first post-reset edge.
                if (in_valid_i && in_ready_q) begin
                    state_d = StInit;
                    round_d = '0;
                end
            end
            StInit: begin
                if (key_ready_i) begin
                    dp_valid = 1'b1;
                    dp_load  = 1'b1;
                    round_d  = RW'(1);
                    state_d  = StRound;
                end
            end
            StRound: begin
                if (key_ready_i) begin
                    dp_valid  = 1'b1;
                    dp_mix_en = 1'b1;
                    round_d   = round_q + RW'(1);
                    if (round_q == LastMixRound) begin
                        state_d = StFinal;
                    end
                end
            end
            StFinal: begin
                if (key_ready_i) begin
                    dp_valid = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                    round_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                round_d = '0;
            end
        endcase

`ifdef AES_ABORT_EN
        // Abort wins over key and output handshakes; the aborted block never reaches DONE.
        if (abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            round_d   = '0;
            dp_valid  = 1'b0;
            dp_load   = 1'b0;
            dp_mix_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            round_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            in_ready_q  <= (state_d == StIdle);
            out_valid_q <= (state_d == StDone);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign round_o     = round_q;
    assign dp_valid_o  = dp_valid;
    assign dp_load_o   = dp_load;
    assign dp_mix_en_o = dp_mix_en;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR=10 and NR=14 instances); abort steps need AES_ABORT_EN.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, key_ready, out_ready;
    logic       in_ready, dp_valid, dp_load, dp_mix, out_valid, busy;
    logic [3:0] round;
`ifdef AES_ABORT_EN
    logic       abort;
`endif

    logic       in_valid14;
    logic       in_ready14, dp_valid14, dp_load14, dp_mix14, out_valid14, busy14;
    logic [3:0] round14;

    int checks = 0;
    int errors = 0;

    int dpv_cnt = 0, mix_cnt = 0, load_cnt = 0;
    int dpv14_cnt = 0, fin14_cnt = 0, max14 = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .RW(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .key_ready_i (key_ready),
        .round_o     (round),
        .dp_valid_o  (dp_valid),
        .dp_load_o   (dp_load),
        .dp_mix_en_o (dp_mix),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef AES_ABORT_EN
        .abort_i     (abort),
`endif
        .busy_o      (busy)
    );

    aes_round_ctrl #(.NR(14), .RW(4)) u_dut14 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid14),
        .in_ready_o  (in_ready14),
        .key_ready_i (1'b1),
        .round_o     (round14),
        .dp_valid_o  (dp_valid14),
        .dp_load_o   (dp_load14),
        .dp_mix_en_o (dp_mix14),
        .out_valid_o (out_valid14),
        .out_ready_i (1'b1),
`ifdef AES_ABORT_EN
        .abort_i     (1'b0),
`endif
        .busy_o      (busy14)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (dp_valid) dpv_cnt <= dpv_cnt + 1;
        if (dp_valid && dp_mix) mix_cnt <= mix_cnt + 1;
        if (dp_valid && dp_load) load_cnt <= load_cnt + 1;
        if (dp_valid14) dpv14_cnt <= dpv14_cnt + 1;
        if (dp_valid14 && (round14 == 4'd14) && !dp_mix14) fin14_cnt <= fin14_cnt + 1;
        if (int'(round14) > max14) max14 <= int'(round14);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    function automatic int b2i(input bit x);
        return x ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int r, input int dv, input int ld, input int mx,
                           input int ov, input int ir, input int bz);
        #1;
        chk({tag, ".round"},     32'(round),     r);
        chk({tag, ".dp_valid"},  32'(dp_valid),  dv);
        chk({tag, ".dp_load"},   32'(dp_load),   ld);
        chk({tag, ".dp_mix"},    32'(dp_mix),    mx);
        chk({tag, ".out_valid"}, 32'(out_valid), ov);
        chk({tag, ".in_ready"},  32'(in_ready),  ir);
        chk({tag, ".busy"},      32'(busy),      bz);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Caller raises in_valid in the accept cycle (cycle 0); checks cycles 1..13.
    task automatic run_block(input string tg);
        int d0, m0, l0;
        d0 = dpv_cnt;
        m0 = mix_cnt;
        l0 = load_cnt;
        for (int k = 1; k <= 12; k++) begin
            next();
            if (k == 1) in_valid = 1'b0;
            chk_all($sformatf("%s.c%0d", tg, k), (k == 1) ? 0 : ((k == 12) ? 10 : k - 1),
                    b2i(k <= 11), b2i(k == 1), b2i(k >= 2 && k <= 10), b2i(k == 12), 0, 1);
        end
        next();
        chk_all({tg, ".c13"}, 0, 0, 0, 0, 0, 1, 0);
        chk({tg, ".dpv_pulses"},  32'(dpv_cnt - d0),  11);
        chk({tg, ".mix_pulses"},  32'(mix_cnt - m0),  9);
        chk({tg, ".load_pulses"}, 32'(load_cnt - l0), 1);
    endtask

    initial begin
        int d0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        key_ready  = 1'b1;
        out_ready  = 1'b1;
        in_valid14 = 1'b0;
`ifdef AES_ABORT_EN
        abort      = 1'b0;
`endif

        // Reset values, with in_valid high to show it is ignored.
        in_valid = 1'b1;
        chk_all("rst", 0, 0, 0, 0, 0, 0, 0);
        next();
        next();
        chk_all("rst_edge", 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk_all("rst_rel", 0, 0, 0, 0, 0, 0, 0);
        next();
        chk_all("rdy_first_edge", 0, 0, 0, 0, 0, 1, 0);

        // Nominal block, key always ready.
        in_valid = 1'b1;
        run_block("nom");

        // Key stall at round 5, then held output with a waiting input.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        d0 = dpv_cnt;
        for (int k = 1; k <= 21; k++) begin
            next();
            if (k == 6) key_ready = 1'b0;
            if (k == 9) key_ready = 1'b1;
            if (k == 19) out_ready = 1'b1;
            if (k == 21) in_valid = 1'b0;
            chk_all($sformatf("stall.c%0d", k),
                    (k == 1 || k >= 20) ? 0 :
                    (k <= 5) ? k - 1 :
                    (k <= 9) ? 5 :
                    (k <= 13) ? k - 4 : 10,
                    b2i(k <= 5 || (k >= 9 && k <= 14) || k == 21),
                    b2i(k == 1 || k == 21),
                    b2i((k >= 2 && k <= 5) || (k >= 9 && k <= 13)),
                    b2i(k >= 15 && k <= 19),
                    b2i(k == 20),
                    b2i(k != 20));
            if (k == 20) chk("stall.dpv_pulses", 32'(dpv_cnt - d0), 11);
        end

        // Reset pulse at round 7 of the block accepted above.
        for (int r = 1; r <= 6; r++) begin
            next();
            chk_all($sformatf("mid.r%0d", r), r, 1, 0, 1, 0, 0, 1);
        end
        next();
        chk("mid.r7_pre", 32'(round), 7);
        rst_n = 1'b0;
        chk_all("mid.rst", 0, 0, 0, 0, 0, 0, 0);
        next();
        rst_n = 1'b1;
        chk_all("mid.rel", 0, 0, 0, 0, 0, 0, 0);
        next();
        chk_all("mid.rdy", 0, 0, 0, 0, 0, 1, 0);
        in_valid = 1'b1;
        run_block("post_rst");

`ifdef AES_ABORT_EN
        // Abort at round 3: back to idle, no output for that block.
        in_valid = 1'b1;
        next();
        in_valid = 1'b0;
        chk_all("abort.c1", 0, 1, 1, 0, 0, 0, 1);
        next();
        chk_all("abort.c2", 1, 1, 0, 1, 0, 0, 1);
        next();
        chk_all("abort.c3", 2, 1, 0, 1, 0, 0, 1);
        next();
        abort = 1'b1;
        chk_all("abort.c4", 3, 0, 0, 0, 0, 0, 1);
        next();
        abort = 1'b0;
        chk_all("abort.c5", 0, 0, 0, 0, 0, 1, 0);
        for (int k = 6; k <= 16; k++) begin
            next();
            #1;
            chk($sformatf("abort.c%0d.out_valid", k), 32'(out_valid), 0);
        end
`endif

        // NR=14 instance.
        chk("nr14.rdy", 32'(in_ready14), 1);
        in_valid14 = 1'b1;
        d0 = dpv14_cnt;
        for (int k = 1; k <= 16; k++) begin
            next();
            if (k == 1) in_valid14 = 1'b0;
            #1;
            chk($sformatf("nr14.c%0d.out_valid", k), 32'(out_valid14), b2i(k == 16));
            if (k == 15) begin
                chk("nr14.final_round", 32'(round14), 14);
                chk("nr14.final_mix", 32'(dp_mix14), 0);
            end
        end
        chk("nr14.dpv_pulses", 32'(dpv14_cnt - d0), 15);
        chk("nr14.final_pulses", 32'(fin14_cnt), 1);
        chk("nr14.max_round", 32'(max14), 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
